abus_pin_frontend: RTL and testbench
====================================

// Module: abus_pin_frontend
// PURPOSE
// - Saturn cartridge A-bus pin front-end, directly upstream of abus_slave_0 in wasca.
// - Synchronises raw CS/RD/WR strobes and demultiplexes the shared 16-bit address/data pins.
// - Sequences the muxing/direction outputs and delivers one clean request per bus cycle, valid/ready style.
// - Returns read data to the pins and holds the Saturn in wait until the response arrives.
// PARAMETERS
// - SYNC_STAGES   2    flops per strobe synchroniser (min 2)
// - SETTLE_CYC    3    clk cycles between a mux/direction change and sampling the pins (min 1)
// - TIMEOUT_CYC   1024 max cycles a cycle may stay in WAIT_RSP or HOLD before forced abort
// PORTS
// - clk              in   1   system clock (clk_clk domain)
// - reset            in   1   synchronous, active-high
// - saturn_reset     in   1   raw Saturn reset, active-low; synchronised internally
// - abus_chipselect  in   3   raw CS0..CS2, active-low
// - abus_read        in   1   raw RD, active-low
// - abus_write       in   2   raw WR per byte lane {upper,lower}, active-low
// - abus_address     in   10  raw A[9:0]
// - abus_ad_in       in   16  pin input side of addressdata
// - abus_ad_out      out  16  pin output data
// - abus_ad_oe       out  1   1 = drive abus_ad_out onto the pins
// - abus_direction   out  1   level-shifter direction; 1 = FPGA->Saturn
// - abus_muxing      out  2   2'b01 = address-high phase, 2'b10 = data phase
// - abus_waitrequest out  1   1 = hold the Saturn in wait
// - req_valid / req_ready  out/in  1   request handshake
// - req_write        out  1   1 = write, 0 = read
// - req_be           out  2   byte enables {upper,lower}; 2'b11 on reads
// - req_cs           out  2   index of the active chipselect (0..2)
// - req_address      out  25  {A[24:10] from abus_ad_in[14:0], A[9:0]}
// - req_wdata        out  16  write data
// - rsp_valid        in   1   read data valid, one-cycle pulse
// - rsp_rdata        in   16  read data
// - timeout_err      out  1   sticky; set on timeout, cleared by reset
// BEHAVIOUR
// - Reset values: abus_ad_oe=0, abus_direction=0, abus_muxing=2'b01, abus_waitrequest=0,
//   req_valid=0, timeout_err=0, all data/address registers 0.
// - Reset, or synced saturn_reset low, forces IDLE and drops any pending req_valid within 1 cycle.
// - Strobes are used only after SYNC_STAGES flops. cs_act = any synced CS low.
// - More than one CS low: lowest index wins.
// - FSM states:
//   - IDLE: muxing=01, oe=0. On the cs_act rising edge -> ADDR and load the settle counter.
//   - ADDR: after SETTLE_CYC cycles latch req_address and req_cs.
//     - Synced RD low -> RD_REQ, muxing=10, direction=1, waitrequest=1.
//     - Any synced WR low -> WR_SET, muxing=10, direction=0.
//     - Neither strobe low: stay, timeout counter running.
//   - WR_SET: after SETTLE_CYC cycles latch req_wdata and req_be = ~WR.
//     Then req_valid=1, waitrequest=1 -> WR_REQ.
//   - WR_REQ: on the req_valid&&req_ready cycle drop req_valid and waitrequest -> HOLD.
//   - RD_REQ: req_valid=1, req_write=0. On accept -> WAIT_RSP.
//   - WAIT_RSP: on rsp_valid register rsp_rdata into abus_ad_out, set oe=1, drop waitrequest -> HOLD.
//     Read latency to the pins: 1 cycle after rsp_valid.
//   - HOLD: wait until cs_act=0 and all strobes are high.
//     Then oe=0, direction=0, muxing=01 -> IDLE.
// - Request fields stay stable while req_valid=1; at most one request is outstanding.
// - CS deasserted mid-cycle (any state except IDLE): return to IDLE next cycle, oe=0, waitrequest=0.
//   - An unaccepted request is withdrawn.
//   - An accepted read's later rsp_valid is discarded.
// - rsp_valid outside WAIT_RSP (other than a discarded read response) is ignored.
// - Timeout: the counter runs in ADDR/WAIT_RSP/HOLD and clears on every state change.
//   At TIMEOUT_CYC: set timeout_err, same cleanup as a CS abort, -> IDLE.
// - Simultaneous RD and WR low in ADDR: read wins.
// CONFIGURATION
// - ABUS_FRONTEND_STATS_EN defined:
//   - adds outputs stat_rd_cnt[15:0], stat_wr_cnt[15:0], stat_abort_cnt[7:0].
//   - Counts accepted reads, accepted writes, and CS aborts plus timeouts.
//   - Counters wrap, reset to 0.
// - Undefined: ports and logic absent; otherwise identical behaviour.
// STRUCTURE
// - Package abus_frontend_pkg:
//   - state enum;
//   - MUX_ADDR=2'b01, MUX_DATA=2'b10;
//   - ADDR_W=25, DATA_W=16.
// - Sub-module abus_sync_bit: parameterised N-flop synchroniser, instanced per strobe (6)
//   and for saturn_reset.
// - FSM, counters and datapath registers live in the top.
// TESTING
// - Read, CS0, A=0x0123456 (A[24:10] on abus_ad_in), SETTLE_CYC=3:
//   req_address=0x0123456, req_cs=0, req_write=0; rsp 0xBEEF -> abus_ad_out=0xBEEF, oe=1 next cycle,
//   waitrequest falls.
// - Write, CS1, WR=2'b10 (lower lane), data 0x00A5, req_ready held low 5 cycles:
//   req_be=2'b01, req_wdata=0x00A5, waitrequest=1 until accept, then 0.
// - CS0 released while in WAIT_RSP, rsp_valid 4 cycles later:
//   IDLE, oe=0, waitrequest=0, response dropped, no spurious request.
// - Strobes held low after HOLD, TIMEOUT_CYC=16: timeout_err=1 after 16 cycles, outputs at idle values.
// - saturn_reset pulsed low during WR_REQ: req_valid=0 within SYNC_STAGES+1 cycles,
//   muxing=01, next cycle works normally.
// - With ABUS_FRONTEND_STATS_EN: 3 reads, 2 writes, 1 abort -> stat_rd_cnt=3, stat_wr_cnt=2,
//   stat_abort_cnt=1.

Source files
------------

// File: rtl/abus_frontend_pkg.sv
// Shared definitions for the Saturn A-bus pin front-end.
// - state_e     : front-end bus-cycle FSM states
// - MUX_ADDR/MUX_DATA : abus_muxing encodings for the external address/data mux
// - ADDR_W/DATA_W     : request address and data widths
// - cs_index()  : lowest active (low) chipselect index
package abus_frontend_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  localparam logic [1:0] MUX_ADDR = 2'b01;
  localparam logic [1:0] MUX_DATA = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_WR_SET   = 3'd2,
    ST_WR_REQ   = 3'd3,
    ST_RD_REQ   = 3'd4,
    ST_WAIT_RSP = 3'd5,
    ST_HOLD     = 3'd6
  } state_e;

  // Several CS low at once: the lowest index takes the cycle.
  function automatic logic [1:0] cs_index(input logic [2:0] cs_n);
    logic [1:0] idx;
    idx = 2'd2;
    if (!cs_n[1]) idx = 2'd1;
    if (!cs_n[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/abus_pin_frontend_sync.sv
// abus_sync_bit: N-flop synchroniser for one raw Saturn-side signal.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high; loads RST_VAL into every stage
//   d_i   in  raw asynchronous input
//   q_o   out synchronised output (last stage)
// All Saturn strobes are active-low, so the default reset value is 1
// (inactive) to avoid a false edge straight out of reset.
module abus_sync_bit #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= {N{RST_VAL}};
    else       sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/abus_pin_frontend.sv
// abus_pin_frontend: Saturn cartridge A-bus pin front-end.
// Synchronises CS/RD/WR and saturn_reset, sequences the external
// address/data mux and level-shifter direction, and turns each Saturn bus
// cycle into one valid/ready request. Read data comes back on rsp_valid
// and is driven onto the pins while waitrequest is released.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   saturn_reset               raw Saturn reset (active-low)
//   abus_chipselect/read/write raw active-low strobes
//   abus_address, abus_ad_in   raw A[9:0] and shared address/data pins
//   abus_ad_out/_oe            pin output data and output enable
//   abus_direction             1 = FPGA->Saturn
//   abus_muxing                01 address-high phase, 10 data phase
//   abus_waitrequest           1 = stall the Saturn
//   req_*                      request channel (valid/ready)
//   rsp_valid/rsp_rdata        read response (one-cycle pulse)
//   timeout_err                sticky timeout flag
// Optional: `ABUS_FRONTEND_STATS_EN adds stat_rd_cnt, stat_wr_cnt,
// stat_abort_cnt (accepted reads, accepted writes, CS aborts + timeouts).
module abus_pin_frontend
  import abus_frontend_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              saturn_reset,
  input  logic [2:0]        abus_chipselect,
  input  logic              abus_read,
  input  logic [1:0]        abus_write,
  input  logic [9:0]        abus_address,
  input  logic [DATA_W-1:0] abus_ad_in,
  output logic [DATA_W-1:0] abus_ad_out,
  output logic              abus_ad_oe,
  output logic              abus_direction,
  output logic [1:0]        abus_muxing,
  output logic              abus_waitrequest,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [1:0]        req_be,
  output logic [1:0]        req_cs,
  output logic [ADDR_W-1:0] req_address,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              timeout_err
`ifdef ABUS_FRONTEND_STATS_EN
  ,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt,
  output logic [7:0]        stat_abort_cnt
`endif
);

  localparam int NSYNC = 7;
  localparam int SW    = $clog2(SETTLE_CYC + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  // Counter loads SETTLE_CYC-1 so the pins are sampled on the
  // SETTLE_CYC-th cycle after the mux/direction change.
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  // ---- synchronisers: {saturn_reset, WR[1:0], RD, CS[2:0]} ----
  logic [NSYNC-1:0] raw_in, syn;
  assign raw_in = {saturn_reset, abus_write, abus_read, abus_chipselect};

  for (genvar g = 0; g < NSYNC; g++) begin : g_sync
    abus_sync_bit #(.N(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .reset(reset),
      .d_i  (raw_in[g]),
      .q_o  (syn[g])
    );
  end

  logic [2:0] cs_s;
  logic       rd_s, srst_n_s;
  logic [1:0] wr_s;
  assign cs_s     = syn[2:0];
  assign rd_s     = syn[3];
  assign wr_s     = syn[5:4];
  assign srst_n_s = syn[6];

  logic cs_act, strobes_idle;
  assign cs_act       = (cs_s != 3'b111);
  assign strobes_idle = !cs_act && rd_s && (wr_s == 2'b11);

  // ---- state and datapath registers ----
  state_e            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              cs_act_q;
  logic              drop_q, drop_d;     // a stale read response is still due
  logic [1:0]        mux_q, mux_d;
  logic              dir_q, dir_d, oe_q, oe_d, wait_q, wait_d;
  logic              vld_q, vld_d, wr_q, wr_d, err_q, err_d;
  logic [1:0]        be_q, be_d, cs_q, cs_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, dout_q, dout_d;

  logic acc, tmo_run, abort_cs, abort_tmo;
  assign acc       = vld_q && req_ready;
  assign tmo_run   = (state_q inside {ST_ADDR, ST_WAIT_RSP, ST_HOLD});
  // HOLD is excluded: CS going away there is the normal end of a cycle.
  assign abort_cs  = !cs_act && !(state_q inside {ST_IDLE, ST_HOLD});
  assign abort_tmo = tmo_run && (tmo_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    tmo_d    = tmo_run ? tmo_q + TW'(1) : tmo_q;
    drop_d   = drop_q;
    mux_d    = mux_q;
    dir_d    = dir_q;
    oe_d     = oe_q;
    wait_d   = wait_q;
    vld_d    = vld_q;
    wr_d     = wr_q;
    be_d     = be_q;
    cs_d     = cs_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    err_d    = err_q;

    if (settle_q != '0) settle_d = settle_q - SW'(1);
    if (rsp_valid && drop_q) drop_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_act && !cs_act_q) begin
          state_d  = ST_ADDR;
          settle_d = SETTLE_LD;
        end
      end
      ST_ADDR: begin
        if (settle_q == '0) begin
          addr_d = {abus_ad_in[14:0], abus_address};
          cs_d   = cs_index(cs_s);
          if (!rd_s) begin          // read wins over a simultaneous write
            state_d = ST_RD_REQ;
            mux_d   = MUX_DATA;
            dir_d   = 1'b1;
            wait_d  = 1'b1;
            vld_d   = 1'b1;
            wr_d    = 1'b0;
            be_d    = 2'b11;
          end else if (wr_s != 2'b11) begin
            state_d  = ST_WR_SET;
            mux_d    = MUX_DATA;
            dir_d    = 1'b0;
            settle_d = SETTLE_LD;
          end
        end
      end
      ST_WR_SET: begin
        if (settle_q == '0) begin
          wdata_d = abus_ad_in;
          be_d    = ~wr_s;
          wr_d    = 1'b1;
          vld_d   = 1'b1;
          wait_d  = 1'b1;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (acc) begin
          vld_d   = 1'b0;
          wait_d  = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_RD_REQ: begin
        if (acc) begin
          vld_d   = 1'b0;
          state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid && !drop_q) begin
          dout_d  = rsp_rdata;
          oe_d    = 1'b1;
          wait_d  = 1'b0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (strobes_idle) begin
          oe_d    = 1'b0;
          dir_d   = 1'b0;
          mux_d   = MUX_ADDR;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Saturn reset, CS abort and timeout all share the same cleanup.
    if (!srst_n_s || abort_cs || abort_tmo) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      wait_d  = 1'b0;
      vld_d   = 1'b0;
      dir_d   = 1'b0;
      mux_d   = MUX_ADDR;
      // An accepted read whose response has not yet been consumed will
      // still produce a rsp_valid; remember to swallow it.
      if ((state_q == ST_RD_REQ && acc) ||
          (state_q == ST_WAIT_RSP && !(rsp_valid && !drop_q)))
        drop_d = 1'b1;
      if (abort_tmo && srst_n_s) err_d = 1'b1;
    end

    if (state_d != state_q) tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      tmo_q    <= '0;
      cs_act_q <= 1'b0;
      drop_q   <= 1'b0;
      mux_q    <= MUX_ADDR;
      dir_q    <= 1'b0;
      oe_q     <= 1'b0;
      wait_q   <= 1'b0;
      vld_q    <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      cs_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      cs_act_q <= cs_act;
      drop_q   <= drop_d;
      mux_q    <= mux_d;
      dir_q    <= dir_d;
      oe_q     <= oe_d;
      wait_q   <= wait_d;
      vld_q    <= vld_d;
      wr_q     <= wr_d;
      be_q     <= be_d;
      cs_q     <= cs_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  assign abus_ad_out      = dout_q;
  assign abus_ad_oe       = oe_q;
  assign abus_direction   = dir_q;
  assign abus_muxing      = mux_q;
  assign abus_waitrequest = wait_q;
  assign req_valid        = vld_q;
  assign req_write        = wr_q;
  assign req_be           = be_q;
  assign req_cs           = cs_q;
  assign req_address      = addr_q;
  assign req_wdata        = wdata_q;
  assign timeout_err      = err_q;

`ifdef ABUS_FRONTEND_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  logic [7:0]  ab_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      ab_cnt_q <= '0;
    end else begin
      if (acc && !wr_q) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (acc && wr_q)  wr_cnt_q <= wr_cnt_q + 16'd1;
      if (srst_n_s && (abort_cs || abort_tmo)) ab_cnt_q <= ab_cnt_q + 8'd1;
    end
  end

  assign stat_rd_cnt    = rd_cnt_q;
  assign stat_wr_cnt    = wr_cnt_q;
  assign stat_abort_cnt = ab_cnt_q;
`endif

endmodule

// File: tb/tb_abus_pin_frontend.sv
// Testbench for abus_pin_frontend. Emulates the Saturn side (strobes and
// the external address/data mux on abus_ad_in) and the downstream slave
// (req_ready / rsp_valid), and checks every request against expectations
// derived from the bus-cycle rules.
module tb_abus_pin_frontend;
  import abus_frontend_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int SETTLE_CYC  = 3;
  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        saturn_reset = 1'b1;
  logic [2:0]  abus_chipselect = 3'b111;
  logic        abus_read = 1'b1;
  logic [1:0]  abus_write = 2'b11;
  logic [9:0]  abus_address = '0;
  logic [15:0] pin_hi = '0, pin_data = '0;
  wire  [15:0] abus_ad_in;
  logic [15:0] abus_ad_out;
  logic        abus_ad_oe, abus_direction, abus_waitrequest;
  logic [1:0]  abus_muxing;
  logic        req_valid, req_write;
  logic        req_ready = 1'b0;
  logic [1:0]  req_be, req_cs;
  logic [24:0] req_address;
  logic [15:0] req_wdata;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_rdata = '0;
  logic        timeout_err;
`ifdef ABUS_FRONTEND_STATS_EN
  logic [15:0] stat_rd_cnt, stat_wr_cnt;
  logic [7:0]  stat_abort_cnt;
`endif

  // External mux model: the pins carry A[24:10] in the address phase and
  // the data word in the data phase.
  assign abus_ad_in = (abus_muxing == 2'b10) ? pin_data : pin_hi;

  always #5 clk = ~clk;

  abus_pin_frontend #(
    .SYNC_STAGES(SYNC_STAGES), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .saturn_reset(saturn_reset),
    .abus_chipselect(abus_chipselect), .abus_read(abus_read), .abus_write(abus_write),
    .abus_address(abus_address), .abus_ad_in(abus_ad_in), .abus_ad_out(abus_ad_out),
    .abus_ad_oe(abus_ad_oe), .abus_direction(abus_direction), .abus_muxing(abus_muxing),
    .abus_waitrequest(abus_waitrequest), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_be(req_be), .req_cs(req_cs), .req_address(req_address),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .timeout_err(timeout_err)
`ifdef ABUS_FRONTEND_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_abort_cnt(stat_abort_cnt)
`endif
  );

  int tests = 0, fails = 0;
  int exp_rd = 0, exp_wr = 0, exp_ab = 0;
  logic [15:0] last_rdata = '0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference rule: the lowest-numbered active-low chipselect is reported.
  function automatic logic [1:0] model_cs(input logic [2:0] cs_n);
    for (int i = 0; i < 3; i++) if (!cs_n[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic start_cycle(input logic [2:0] cs_n, input logic [24:0] addr,
                             input logic rd, input logic [1:0] wr_n, input logic [15:0] wd);
    abus_address    = addr[9:0];
    pin_hi          = {1'($urandom), addr[24:10]};
    pin_data        = wd;
    abus_chipselect = cs_n;
    abus_read       = ~rd;
    abus_write      = wr_n;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!req_valid && n < 40) begin tick(1); n++; end
    ok = req_valid;
  endtask

  task automatic release_bus(output bit ok);
    int n = 0;
    abus_chipselect = 3'b111; abus_read = 1'b1; abus_write = 2'b11;
    while (!(abus_muxing == 2'b01 && !abus_ad_oe && !abus_waitrequest &&
             !req_valid && !abus_direction) && n < 40) begin tick(1); n++; end
    ok = (n < 40);
    tick(SYNC_STAGES + 2);
  endtask

  task automatic do_read(input string name, input logic [2:0] cs_n, input logic [24:0] addr,
                         input logic [15:0] rdata, input int rdy_dly, input int rsp_dly,
                         input bit both, input bit hold);
    bit ok;
    start_cycle(cs_n, addr, 1'b1, both ? 2'($urandom_range(0, 2)) : 2'b11, 16'h0);
    wait_valid(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL %s_valid: req_valid never rose, required 1", name);
    end else begin
      if (req_address !== addr || req_cs !== model_cs(cs_n) || req_write !== 1'b0 ||
          req_be !== 2'b11 || abus_waitrequest !== 1'b1 || abus_direction !== 1'b1 ||
          abus_muxing !== 2'b10) begin
        fails++;
        $display("FAIL %s_req: addr=%h cs=%0d wr=%b be=%b wait=%b dir=%b mux=%b, required addr=%h cs=%0d wr=0 be=11 wait=1 dir=1 mux=10",
                 name, req_address, req_cs, req_write, req_be, abus_waitrequest,
                 abus_direction, abus_muxing, addr, model_cs(cs_n));
      end
      for (int i = 0; i < rdy_dly; i++) begin
        tick(1); tests++;
        if (req_valid !== 1'b1 || req_address !== addr || abus_waitrequest !== 1'b1) begin
          fails++;
          $display("FAIL %s_stall: valid=%b addr=%h wait=%b, required 1 %h 1",
                   name, req_valid, req_address, abus_waitrequest, addr);
        end
      end
      req_ready = 1'b1; tick(1); req_ready = 1'b0; exp_rd++;
      tests++;
      if (req_valid !== 1'b0 || abus_waitrequest !== 1'b1) begin
        fails++;
        $display("FAIL %s_accept: valid=%b wait=%b, required 0 1", name, req_valid, abus_waitrequest);
      end
      tick(rsp_dly);
      rsp_valid = 1'b1; rsp_rdata = rdata; tick(1); rsp_valid = 1'b0;
      tests++;
      if (abus_ad_out !== rdata || abus_ad_oe !== 1'b1 || abus_waitrequest !== 1'b0) begin
        fails++;
        $display("FAIL %s_rsp: dout=%h oe=%b wait=%b, required %h 1 0",
                 name, abus_ad_out, abus_ad_oe, abus_waitrequest, rdata);
      end
      last_rdata = rdata;
    end
    if (!hold) begin
      release_bus(ok); tests++;
      if (!ok) begin fails++; $display("FAIL %s_release: bus did not return idle", name); end
    end
  endtask

  task automatic do_write(input string name, input logic [2:0] cs_n, input logic [24:0] addr,
                          input logic [1:0] wr_n, input logic [15:0] wd, input int rdy_dly);
    bit ok;
    start_cycle(cs_n, addr, 1'b0, wr_n, wd);
    wait_valid(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL %s_valid: req_valid never rose, required 1", name);
    end else begin
      if (req_address !== addr || req_cs !== model_cs(cs_n) || req_write !== 1'b1 ||
          req_be !== ~wr_n || req_wdata !== wd || abus_waitrequest !== 1'b1 ||
          abus_direction !== 1'b0 || abus_muxing !== 2'b10) begin
        fails++;
        $display("FAIL %s_req: addr=%h cs=%0d wr=%b be=%b data=%h wait=%b dir=%b mux=%b, required addr=%h cs=%0d wr=1 be=%b data=%h wait=1 dir=0 mux=10",
                 name, req_address, req_cs, req_write, req_be, req_wdata, abus_waitrequest,
                 abus_direction, abus_muxing, addr, model_cs(cs_n), ~wr_n, wd);
      end
      for (int i = 0; i < rdy_dly; i++) begin
        tick(1); tests++;
        if (req_valid !== 1'b1 || req_wdata !== wd || req_be !== ~wr_n || abus_waitrequest !== 1'b1) begin
          fails++;
          $display("FAIL %s_stall: valid=%b data=%h be=%b wait=%b, required 1 %h %b 1",
                   name, req_valid, req_wdata, req_be, abus_waitrequest, wd, ~wr_n);
        end
      end
      req_ready = 1'b1; tick(1); req_ready = 1'b0; exp_wr++;
      tests++;
      if (req_valid !== 1'b0 || abus_waitrequest !== 1'b0) begin
        fails++;
        $display("FAIL %s_accept: valid=%b wait=%b, required 0 0", name, req_valid, abus_waitrequest);
      end
    end
    release_bus(ok); tests++;
    if (!ok) begin fails++; $display("FAIL %s_release: bus did not return idle", name); end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(3); reset = 1'b0; tick(1);
    tests++;
    if (abus_ad_oe !== 1'b0 || abus_direction !== 1'b0 || abus_muxing !== 2'b01 ||
        abus_waitrequest !== 1'b0 || req_valid !== 1'b0 || timeout_err !== 1'b0 ||
        abus_ad_out !== 16'h0 || req_address !== 25'h0 || req_wdata !== 16'h0) begin
      fails++;
      $display("FAIL reset: oe=%b dir=%b mux=%b wait=%b valid=%b err=%b dout=%h addr=%h wdata=%h, required 0 0 01 0 0 0 0 0 0",
               abus_ad_oe, abus_direction, abus_muxing, abus_waitrequest, req_valid,
               timeout_err, abus_ad_out, req_address, req_wdata);
    end
    tick(SYNC_STAGES + 2);
  endtask

  task automatic test_read();
    do_read("read_cs0", 3'b110, 25'h0123456, 16'hBEEF, 1, 2, 1'b0, 1'b0);
    do_read("read_cs_prio", 3'b010, 25'h1ABCDEF, 16'h1234, 0, 0, 1'b0, 1'b0);
    do_read("read_wins", 3'b011, 25'h0FF00FF, 16'h5A5A, 2, 1, 1'b1, 1'b0);
  endtask

  task automatic test_write();
    do_write("write_cs1", 3'b101, 25'h00003FF, 2'b10, 16'h00A5, 5);
    do_write("write_upper", 3'b011, 25'h1555555, 2'b01, 16'hC300, 0);
    do_write("write_word", 3'b100, 25'h0AAAAAA, 2'b00, 16'hF00D, 2);
  endtask

  task automatic test_cs_abort();
    bit ok; int n;
    start_cycle(3'b110, 25'h0042042, 1'b1, 2'b11, 16'h0);
    wait_valid(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL abort_valid: req_valid never rose, required 1"); end
    req_ready = 1'b1; tick(1); req_ready = 1'b0; exp_rd++;
    tick(2);
    tests++;
    if (abus_waitrequest !== 1'b1) begin
      fails++; $display("FAIL abort_wait: wait=%b, required 1", abus_waitrequest);
    end
    abus_chipselect = 3'b111; abus_read = 1'b1;
    n = 0;
    while ((abus_muxing !== 2'b01 || abus_waitrequest !== 1'b0 || abus_ad_oe !== 1'b0) &&
           n < SYNC_STAGES + 1) begin tick(1); n++; end
    exp_ab++;
    tests++;
    if (abus_muxing !== 2'b01 || abus_waitrequest !== 1'b0 || abus_ad_oe !== 1'b0 ||
        abus_direction !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: mux=%b wait=%b oe=%b dir=%b, required 01 0 0 0",
               abus_muxing, abus_waitrequest, abus_ad_oe, abus_direction);
    end
    tick(4 - n);
    rsp_valid = 1'b1; rsp_rdata = 16'hDEAD; tick(1); rsp_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (req_valid !== 1'b0 || abus_ad_oe !== 1'b0 || abus_ad_out !== last_rdata ||
          abus_waitrequest !== 1'b0) begin
        fails++;
        $display("FAIL abort_drop: valid=%b oe=%b dout=%h wait=%b, required 0 0 %h 0",
                 req_valid, abus_ad_oe, abus_ad_out, abus_waitrequest, last_rdata);
      end
      tick(1);
    end
    release_bus(ok);
    do_read("after_abort", 3'b101, 25'h1000001, 16'h7777, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    bit ok;
    do_read("tmo_read", 3'b110, 25'h0033333, 16'h6502, 0, 0, 1'b0, 1'b1);
    tick(TIMEOUT_CYC - 1);
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++; $display("FAIL timeout_early: err=%b, required 0", timeout_err);
    end
    tick(1); exp_ab++;
    tests++;
    if (timeout_err !== 1'b1 || abus_ad_oe !== 1'b0 || abus_waitrequest !== 1'b0 ||
        abus_muxing !== 2'b01 || abus_direction !== 1'b0 || req_valid !== 1'b0) begin
      fails++;
      $display("FAIL timeout: err=%b oe=%b wait=%b mux=%b dir=%b valid=%b, required 1 0 0 01 0 0",
               timeout_err, abus_ad_oe, abus_waitrequest, abus_muxing, abus_direction, req_valid);
    end
    release_bus(ok);
    tests++;
    if (timeout_err !== 1'b1) begin
      fails++; $display("FAIL timeout_sticky: err=%b, required 1", timeout_err);
    end
  endtask

  task automatic test_saturn_reset();
    bit ok; int n;
    start_cycle(3'b101, 25'h0101010, 1'b0, 2'b00, 16'h9999);
    wait_valid(ok);
    tick(2);
    tests++;
    if (!ok || req_valid !== 1'b1) begin
      fails++; $display("FAIL srst_pre: valid=%b, required 1", req_valid);
    end
    saturn_reset = 1'b0; tick(1); n = 1; saturn_reset = 1'b1;
    while (req_valid && n < SYNC_STAGES + 1) begin tick(1); n++; end
    tests++;
    if (req_valid !== 1'b0 || abus_muxing !== 2'b01 || abus_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL srst_drop: valid=%b mux=%b wait=%b, required 0 01 0",
               req_valid, abus_muxing, abus_waitrequest);
    end
    release_bus(ok);
    do_read("after_srst", 3'b110, 25'h0F0F0F0, 16'hAAAA, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] cs_n; logic [24:0] a; logic [15:0] d; logic [1:0] wr_n;
    for (int t = 0; t < 20; t++) begin
      cs_n = 3'($urandom_range(0, 6));
      a    = 25'($urandom);
      d    = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       wr_n = 2'b10;
        1:       wr_n = 2'b01;
        default: wr_n = 2'b00;
      endcase
      if ($urandom_range(0, 1) == 0)
        do_read("rand_read", cs_n, a, d, $urandom_range(0, 4), $urandom_range(0, 5),
                1'($urandom), 1'b0);
      else
        do_write("rand_write", cs_n, a, wr_n, d, $urandom_range(0, 4));
    end
  endtask

  task automatic test_final_reset();
    reset = 1'b1; tick(2); reset = 1'b0; tick(1);
    tests++;
    if (timeout_err !== 1'b0 || req_valid !== 1'b0 || abus_muxing !== 2'b01) begin
      fails++;
      $display("FAIL final_reset: err=%b valid=%b mux=%b, required 0 0 01",
               timeout_err, req_valid, abus_muxing);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_cs_abort();
    test_timeout();
    test_saturn_reset();
    test_random();
`ifdef ABUS_FRONTEND_STATS_EN
    tests++;
    if (stat_rd_cnt !== 16'(exp_rd) || stat_wr_cnt !== 16'(exp_wr) ||
        stat_abort_cnt !== 8'(exp_ab)) begin
      fails++;
      $display("FAIL stats: rd=%0d wr=%0d ab=%0d, required %0d %0d %0d",
               stat_rd_cnt, stat_wr_cnt, stat_abort_cnt, exp_rd, exp_wr, exp_ab);
    end
`endif
    test_final_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
